// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_queue
// Description : Reservation station / issue queue between rename-dispatch and
//               register read. Holds up to RS_ENTRIES renamed micro-ops,
//               wakes source operands from NUM_WB writeback channels and
//               issues the oldest fully-ready entry over a valid/ready
//               handshake.
// Ports       : clk, rst_n            - clock, async active-low reset
//               flush_i               - synchronous squash of all entries
//               disp_*                - dispatch request, fields, ready
//               wb_valid_i, wb_tag_i  - wakeup channels (channel k at
//                                       [k*PREG_W +: PREG_W])
//               issue_*               - selected entry and handshake
//               occupancy_o           - registered count of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_queue #(
    parameter  int RS_ENTRIES = 8,
    parameter  int NUM_PREGS  = 128,
    parameter  int NUM_WB     = 4,
    parameter  int OP_W       = 6,
    localparam int PREG_W     = $clog2(NUM_PREGS),
    localparam int CNT_W      = $clog2(RS_ENTRIES) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  logic [OP_W-1:0]          disp_op_i,
    input  logic [PREG_W-1:0]        disp_src1_idx_i,
    input  logic [PREG_W-1:0]        disp_src2_idx_i,
    input  logic [PREG_W-1:0]        disp_dst_idx_i,
    input  logic                     disp_src1_rdy_i,
    input  logic                     disp_src2_rdy_i,
    input  logic [31:0]              disp_imm_i,
    input  logic [NUM_WB-1:0]        wb_valid_i,
    input  logic [NUM_WB*PREG_W-1:0] wb_tag_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [OP_W-1:0]          issue_op_o,
    output logic [PREG_W-1:0]        issue_src1_idx_o,
    output logic [PREG_W-1:0]        issue_src2_idx_o,
    output logic [PREG_W-1:0]        issue_dst_idx_o,
    output logic [31:0]              issue_imm_o,
    output logic [CNT_W-1:0]         occupancy_o
);

    localparam int               IDX_W    = $clog2(RS_ENTRIES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RS_ENTRIES);

    // Entry state
    logic [RS_ENTRIES-1:0] valid_q, valid_d;
    logic [RS_ENTRIES-1:0] src1_rdy_q, src1_rdy_d;
    logic [RS_ENTRIES-1:0] src2_rdy_q, src2_rdy_d;
    logic [OP_W-1:0]       op_q   [RS_ENTRIES];
    logic [OP_W-1:0]       op_d   [RS_ENTRIES];
    logic [PREG_W-1:0]     src1_q [RS_ENTRIES];
    logic [PREG_W-1:0]     src1_d [RS_ENTRIES];
    logic [PREG_W-1:0]     src2_q [RS_ENTRIES];
    logic [PREG_W-1:0]     src2_d [RS_ENTRIES];
    logic [PREG_W-1:0]     dst_q  [RS_ENTRIES];
    logic [PREG_W-1:0]     dst_d  [RS_ENTRIES];
    logic [31:0]           imm_q  [RS_ENTRIES];
    logic [31:0]           imm_d  [RS_ENTRIES];
    // older_q[i][j] == 1 means entry i was dispatched before entry j
    logic [RS_ENTRIES-1:0] older_q [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] older_d [RS_ENTRIES];
    logic [CNT_W-1:0]      occ_q, occ_d;

    logic [RS_ENTRIES-1:0] w_cand;
    logic [RS_ENTRIES-1:0] w_grant;
    logic [IDX_W-1:0]      w_issue_idx;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_any_cand;
    logic                  w_issue_fire;
    logic                  w_disp_fire;

    // True when any active wakeup channel carries the given tag
    function automatic logic wb_hit(input logic [PREG_W-1:0]        tag,
                                    input logic [NUM_WB-1:0]        vld,
                                    input logic [NUM_WB*PREG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < NUM_WB; c++) begin
            if (vld[c] && (tags[c*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Oldest-ready select: an entry wins when no other candidate is older.
    // The age matrix is a strict total order over valid entries, so at most
    // one grant bit is set.
    always_comb begin
        w_cand      = valid_q & src1_rdy_q & src2_rdy_q;
        w_grant     = w_cand;
        w_issue_idx = '0;
        w_free_idx  = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (w_cand[j] && older_q[j][i]) w_grant[i] = 1'b0;
            end
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (w_grant[i]) w_issue_idx = IDX_W'(i);
        end
        // Descending scan leaves the lowest free index
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) w_free_idx = IDX_W'(i);
        end
    end

    assign w_any_cand    = |w_cand;
    assign issue_valid_o = w_any_cand & ~flush_i;
    assign disp_ready_o  = (occ_q != FULL_CNT);
    assign occupancy_o   = occ_q;
    assign w_issue_fire  = issue_valid_o & issue_ready_i;
    assign w_disp_fire   = disp_valid_i & disp_ready_o & ~flush_i;

    // Fields read straight from registered state; zero when nothing is ready
    assign issue_op_o       = w_any_cand ? op_q[w_issue_idx]   : '0;
    assign issue_src1_idx_o = w_any_cand ? src1_q[w_issue_idx] : '0;
    assign issue_src2_idx_o = w_any_cand ? src2_q[w_issue_idx] : '0;
    assign issue_dst_idx_o  = w_any_cand ? dst_q[w_issue_idx]  : '0;
    assign issue_imm_o      = w_any_cand ? imm_q[w_issue_idx]  : '0;

    always_comb begin
        valid_d    = valid_q;
        src1_rdy_d = src1_rdy_q;
        src2_rdy_d = src2_rdy_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        dst_d      = dst_q;
        imm_d      = imm_q;
        older_d    = older_q;
        occ_d      = '0;

        // Wakeup: ready bits are sticky while the entry is valid
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (valid_q[i]) begin
                src1_rdy_d[i] = src1_rdy_q[i] | wb_hit(src1_q[i], wb_valid_i, wb_tag_i);
                src2_rdy_d[i] = src2_rdy_q[i] | wb_hit(src2_q[i], wb_valid_i, wb_tag_i);
            end
        end

        if (w_issue_fire) valid_d[w_issue_idx] = 1'b0;

        if (w_disp_fire) begin
            valid_d[w_free_idx]    = 1'b1;
            op_d[w_free_idx]       = disp_op_i;
            src1_d[w_free_idx]     = disp_src1_idx_i;
            src2_d[w_free_idx]     = disp_src2_idx_i;
            dst_d[w_free_idx]      = disp_dst_idx_i;
            imm_d[w_free_idx]      = disp_imm_i;
            src1_rdy_d[w_free_idx] = disp_src1_rdy_i | (disp_src1_idx_i == '0) |
                                     wb_hit(disp_src1_idx_i, wb_valid_i, wb_tag_i);
            src2_rdy_d[w_free_idx] = disp_src2_rdy_i | (disp_src2_idx_i == '0) |
                                     wb_hit(disp_src2_idx_i, wb_valid_i, wb_tag_i);
            // New entry is younger than every currently valid entry; both its
            // row and column are rewritten so stale age bits never survive.
            for (int j = 0; j < RS_ENTRIES; j++) begin
                older_d[j][w_free_idx] = valid_q[j];
            end
            older_d[w_free_idx] = '0;
        end

        if (flush_i) begin
            valid_d = '0;
            for (int i = 0; i < RS_ENTRIES; i++) older_d[i] = '0;
        end

        for (int i = 0; i < RS_ENTRIES; i++) begin
            occ_d = occ_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            op_q       <= '{default: '0};
            src1_q     <= '{default: '0};
            src2_q     <= '{default: '0};
            dst_q      <= '{default: '0};
            imm_q      <= '{default: '0};
            older_q    <= '{default: '0};
            occ_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            src1_rdy_q <= src1_rdy_d;
            src2_rdy_q <= src2_rdy_d;
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            older_q    <= older_d;
            occ_q      <= occ_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_issue_queue
// Description : Self-checking bench for rs_issue_queue. Scenario tasks drive
//               dispatch/wakeup/flush/reset stimulus and check status outputs
//               inline; a scoreboard queue holds the expected issue sequence
//               and is compared on every issue handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_queue;

    localparam int RS_ENTRIES = 8;
    localparam int NUM_PREGS  = 128;
    localparam int NUM_WB     = 4;
    localparam int OP_W       = 6;
    localparam int PREG_W     = 7;
    localparam int CNT_W      = 4;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic                     disp_valid;
    logic                     disp_ready;
    logic [OP_W-1:0]          disp_op;
    logic [PREG_W-1:0]        disp_src1, disp_src2, disp_dst;
    logic                     disp_r1, disp_r2;
    logic [31:0]              disp_imm;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*PREG_W-1:0] wb_tag;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [OP_W-1:0]          issue_op;
    logic [PREG_W-1:0]        issue_src1, issue_src2, issue_dst;
    logic [31:0]              issue_imm;
    logic [CNT_W-1:0]         occupancy;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [PREG_W-1:0] s1;
        logic [PREG_W-1:0] s2;
        logic [PREG_W-1:0] dst;
        logic [31:0]       imm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    rs_issue_queue #(
        .RS_ENTRIES (RS_ENTRIES),
        .NUM_PREGS  (NUM_PREGS),
        .NUM_WB     (NUM_WB),
        .OP_W       (OP_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush),
        .disp_valid_i     (disp_valid),
        .disp_ready_o     (disp_ready),
        .disp_op_i        (disp_op),
        .disp_src1_idx_i  (disp_src1),
        .disp_src2_idx_i  (disp_src2),
        .disp_dst_idx_i   (disp_dst),
        .disp_src1_rdy_i  (disp_r1),
        .disp_src2_rdy_i  (disp_r2),
        .disp_imm_i       (disp_imm),
        .wb_valid_i       (wb_valid),
        .wb_tag_i         (wb_tag),
        .issue_valid_o    (issue_valid),
        .issue_ready_i    (issue_ready),
        .issue_op_o       (issue_op),
        .issue_src1_idx_o (issue_src1),
        .issue_src2_idx_o (issue_src2),
        .issue_dst_idx_o  (issue_dst),
        .issue_imm_o      (issue_imm),
        .occupancy_o      (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required bench to finish");
        $fatal(1);
    end

    // Opcode and immediate are derived from the destination tag
    function automatic logic [OP_W-1:0] op_of(input logic [PREG_W-1:0] d);
        return d[5:0] ^ 6'h2A;
    endfunction

    function automatic logic [31:0] imm_of(input logic [PREG_W-1:0] d);
        return 32'hC0DE_0000 + 32'(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        disp_op    = '0;
        disp_src1  = '0;
        disp_src2  = '0;
        disp_dst   = '0;
        disp_r1    = 1'b0;
        disp_r2    = 1'b0;
        disp_imm   = '0;
        wb_valid   = '0;
        wb_tag     = '0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [PREG_W-1:0] s1, input logic r1,
                        input logic [PREG_W-1:0] s2, input logic r2,
                        input logic [PREG_W-1:0] d);
        disp_valid = 1'b1;
        disp_op    = op_of(d);
        disp_src1  = s1;
        disp_r1    = r1;
        disp_src2  = s2;
        disp_r2    = r2;
        disp_dst   = d;
        disp_imm   = imm_of(d);
    endtask

    task automatic push_exp(input logic [PREG_W-1:0] s1, input logic [PREG_W-1:0] s2,
                            input logic [PREG_W-1:0] d);
        exp_t e;
        e.op  = op_of(d);
        e.s1  = s1;
        e.s2  = s2;
        e.dst = d;
        e.imm = imm_of(d);
        sb.push_back(e);
    endtask

    task automatic wake(input int ch, input logic [PREG_W-1:0] tag);
        wb_valid[ch]                 = 1'b1;
        wb_tag[ch*PREG_W +: PREG_W]  = tag;
    endtask

    // Scoreboard: every issue handshake must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue: got dst=%0d, required no issue", issue_dst);
            end else begin
                mon_e = sb.pop_front();
                if (issue_op !== mon_e.op || issue_src1 !== mon_e.s1 || issue_src2 !== mon_e.s2 ||
                    issue_dst !== mon_e.dst || issue_imm !== mon_e.imm) begin
                    bad++;
                    $display("FAIL issue_fields: got op=%0h s1=%0d s2=%0d dst=%0d imm=%0h, required op=%0h s1=%0d s2=%0d dst=%0d imm=%0h",
                             issue_op, issue_src1, issue_src2, issue_dst, issue_imm,
                             mon_e.op, mon_e.s1, mon_e.s2, mon_e.dst, mon_e.imm);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n       = 1'b0;
        issue_ready = 1'b0;
        idle();
        #2;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_iv: got %b required 0", issue_valid); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL rst_dr: got %b required 1", disp_ready); end
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL rst_occ: got %0d required 0", occupancy); end
        total++; if (issue_dst !== 7'd0 || issue_imm !== 32'd0 || issue_op !== 6'd0) begin
            bad++; $display("FAIL rst_fields: got dst=%0d imm=%0h op=%0h required all 0", issue_dst, issue_imm, issue_op); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        total++; if (occupancy !== 4'd0 || disp_ready !== 1'b1) begin
            bad++; $display("FAIL rst_release: got occ=%0d dr=%b required occ=0 dr=1", occupancy, disp_ready); end
    endtask

    task automatic test_in_order();
        issue_ready = 1'b1;
        disp(7'd1, 1'b1, 7'd2, 1'b1, 7'd5); push_exp(7'd1, 7'd2, 7'd5);
        @(negedge clk);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL ord_c0: got iv=%b required 0", issue_valid); end
        tick();
        disp(7'd3, 1'b1, 7'd4, 1'b1, 7'd6); push_exp(7'd3, 7'd4, 7'd6);
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd5 || occupancy !== 4'd1) begin
            bad++; $display("FAIL ord_c1: got iv=%b dst=%0d occ=%0d required 1/5/1", issue_valid, issue_dst, occupancy); end
        tick();
        // Tag 0 is ready even with the rename ready flags low
        disp(7'd0, 1'b0, 7'd0, 1'b0, 7'd7); push_exp(7'd0, 7'd0, 7'd7);
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd6 || occupancy !== 4'd1) begin
            bad++; $display("FAIL ord_c2: got iv=%b dst=%0d occ=%0d required 1/6/1", issue_valid, issue_dst, occupancy); end
        tick();
        idle();
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd7 || occupancy !== 4'd1) begin
            bad++; $display("FAIL ord_c3: got iv=%b dst=%0d occ=%0d required 1/7/1", issue_valid, issue_dst, occupancy); end
        tick();
        @(negedge clk);
        total++; if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL ord_c4: got iv=%b occ=%0d required 0/0", issue_valid, occupancy); end
        tick();
    endtask

    task automatic test_wakeup_order();
        issue_ready = 1'b1;
        disp(7'd20, 1'b0, 7'd0, 1'b0, 7'd10);
        @(negedge clk);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wk_c0: got iv=%b required 0", issue_valid); end
        tick();
        disp(7'd21, 1'b1, 7'd22, 1'b1, 7'd11); push_exp(7'd21, 7'd22, 7'd11);
        @(negedge clk);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wk_c1: got iv=%b required 0", issue_valid); end
        tick();
        idle();
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd11 || occupancy !== 4'd2) begin
            bad++; $display("FAIL wk_c2: got iv=%b dst=%0d occ=%0d required 1/11/2", issue_valid, issue_dst, occupancy); end
        tick();
        wake(3, 7'd20); wake(1, 7'd0); push_exp(7'd20, 7'd0, 7'd10);
        @(negedge clk);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wk_c3: got iv=%b required 0", issue_valid); end
        tick();
        idle();
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd10) begin
            bad++; $display("FAIL wk_c4: got iv=%b dst=%0d required 1/10", issue_valid, issue_dst); end
        tick();
        @(negedge clk);
        total++; if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL wk_c5: got iv=%b occ=%0d required 0/0", issue_valid, occupancy); end
        tick();
    endtask

    task automatic test_same_cycle_wakeup();
        issue_ready = 1'b1;
        disp(7'd30, 1'b1, 7'd33, 1'b0, 7'd12); wake(0, 7'd33); push_exp(7'd30, 7'd33, 7'd12);
        @(negedge clk);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL scw_c0: got iv=%b required 0", issue_valid); end
        tick();
        idle();
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd12) begin
            bad++; $display("FAIL scw_c1: got iv=%b dst=%0d required 1/12", issue_valid, issue_dst); end
        tick();
    endtask

    // A younger entry reusing a lower slot must still lose to an older one
    task automatic test_age_order();
        issue_ready = 1'b0;
        disp(7'd1, 1'b1, 7'd1, 1'b1, 7'd40);
        tick();
        disp(7'd51, 1'b0, 7'd0, 1'b1, 7'd41);
        tick();
        idle();
        issue_ready = 1'b1; push_exp(7'd1, 7'd1, 7'd40);
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd40) begin
            bad++; $display("FAIL age_c2: got iv=%b dst=%0d required 1/40", issue_valid, issue_dst); end
        tick();
        issue_ready = 1'b0;
        disp(7'd2, 1'b1, 7'd3, 1'b1, 7'd42); wake(2, 7'd51);
        tick();
        idle();
        issue_ready = 1'b1; push_exp(7'd51, 7'd0, 7'd41); push_exp(7'd2, 7'd3, 7'd42);
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd41) begin
            bad++; $display("FAIL age_c4: got iv=%b dst=%0d required 1/41", issue_valid, issue_dst); end
        tick();
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd42) begin
            bad++; $display("FAIL age_c5: got iv=%b dst=%0d required 1/42", issue_valid, issue_dst); end
        tick();
    endtask

    task automatic test_full();
        int n;
        issue_ready = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            disp(7'd40, 1'b0, 7'd0, 1'b1, 7'(16 + i));
            @(negedge clk);
            total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL full_fill%0d: got dr=%b required 1", i, disp_ready); end
            tick();
        end
        disp(7'd9, 1'b1, 7'd9, 1'b1, 7'd31);
        @(negedge clk);
        total++; if (disp_ready !== 1'b0 || occupancy !== 4'd8 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL full_c8: got dr=%b occ=%0d iv=%b required 0/8/0", disp_ready, occupancy, issue_valid); end
        tick();
        @(negedge clk);
        total++; if (disp_ready !== 1'b0 || occupancy !== 4'd8) begin
            bad++; $display("FAIL full_c9: got dr=%b occ=%0d required 0/8", disp_ready, occupancy); end
        tick();
        idle();
        issue_ready = 1'b1;
        wake(2, 7'd40);
        for (int i = 0; i < RS_ENTRIES; i++) push_exp(7'd40, 7'd0, 7'(16 + i));
        @(negedge clk);
        total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b0) begin
            bad++; $display("FAIL full_c10: got iv=%b dr=%b required 0/0", issue_valid, disp_ready); end
        tick();
        idle();
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd16 || disp_ready !== 1'b0) begin
            bad++; $display("FAIL full_c11: got iv=%b dst=%0d dr=%b required 1/16/0", issue_valid, issue_dst, disp_ready); end
        tick();
        @(negedge clk);
        total++; if (disp_ready !== 1'b1 || occupancy !== 4'd7 || issue_dst !== 7'd17) begin
            bad++; $display("FAIL full_c12: got dr=%b occ=%0d dst=%0d required 1/7/17", disp_ready, occupancy, issue_dst); end
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL full_drain: got %0d pending, required 0", sb.size()); end
        tick();
        @(negedge clk);
        total++; if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL full_empty: got occ=%0d iv=%b required 0/0", occupancy, issue_valid); end
        tick();
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(7'd1, 1'b1, 7'd2, 1'b1, 7'(50 + i));
            tick();
        end
        idle();
        @(negedge clk);
        total++; if (occupancy !== 4'd5 || issue_valid !== 1'b1) begin
            bad++; $display("FAIL fl_pre: got occ=%0d iv=%b required 5/1", occupancy, issue_valid); end
        tick();
        flush = 1'b1; issue_ready = 1'b1;
        disp(7'd5, 1'b1, 7'd5, 1'b1, 7'd60);
        @(negedge clk);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL fl_iv: got iv=%b required 0", issue_valid); end
        tick();
        idle();
        @(negedge clk);
        total++; if (occupancy !== 4'd0 || issue_valid !== 1'b0 || disp_ready !== 1'b1) begin
            bad++; $display("FAIL fl_post: got occ=%0d iv=%b dr=%b required 0/0/1", occupancy, issue_valid, disp_ready); end
        tick();
        @(negedge clk);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL fl_post2: got iv=%b required 0", issue_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(7'd1, 1'b1, 7'd2, 1'b1, 7'(70 + i));
            tick();
        end
        idle();
        @(negedge clk);
        total++; if (occupancy !== 4'd4 || issue_valid !== 1'b1) begin
            bad++; $display("FAIL ar_pre: got occ=%0d iv=%b required 4/1", occupancy, issue_valid); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (issue_valid !== 1'b0 || occupancy !== 4'd0 || disp_ready !== 1'b1 || issue_dst !== 7'd0) begin
            bad++; $display("FAIL ar_clear: got iv=%b occ=%0d dr=%b dst=%0d required 0/0/1/0",
                            issue_valid, occupancy, disp_ready, issue_dst); end
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        issue_ready = 1'b1;
        disp(7'd1, 1'b1, 7'd2, 1'b1, 7'd77); push_exp(7'd1, 7'd2, 7'd77);
        tick();
        idle();
        @(negedge clk);
        total++; if (issue_valid !== 1'b1 || issue_dst !== 7'd77 || occupancy !== 4'd1) begin
            bad++; $display("FAIL ar_after: got iv=%b dst=%0d occ=%0d required 1/77/1", issue_valid, issue_dst, occupancy); end
        tick();
        @(negedge clk);
        total++; if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL ar_empty: got iv=%b occ=%0d required 0/0", issue_valid, occupancy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_wakeup_order();
        test_same_cycle_wakeup();
        test_age_order();
        test_full();
        test_flush();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_issue_queue.md
# rs_issue_queue

Parametrised reservation station / issue queue between rename-dispatch and register read. It holds up to RS_ENTRIES renamed micro-ops, tracks operand readiness from NUM_WB writeback wakeup channels, and issues the oldest fully-ready entry each cycle over a valid/ready handshake. It replaces the fixed-size RS, adding multi-channel wakeup, oldest-first selection, occupancy reporting and pipeline flush.

## Interface
- RS_ENTRIES, 8, queue depth (≥2)
- NUM_PREGS, 128, physical registers; PREG_W = $clog2(NUM_PREGS)
- NUM_WB, 4, wakeup channels (one per FU writeback; default matches NUM_FUS)
- OP_W, 6, opcode field width (holds instr_opcode encoding)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists
- disp_op  in  OP_W  opcode
- disp_src1_idx, disp_src2_idx, disp_dst_idx  in  PREG_W  physical tags
- disp_src1_rdy, disp_src2_rdy  in  1  operand already available at rename
- disp_imm  in  32  immediate
- wb_valid  in  NUM_WB  wakeup strobes
- wb_tag  in  NUM_WB*PREG_W  wakeup tags, channel k at [k*PREG_W +: PREG_W]
- issue_valid  out  1  selected entry present
- issue_ready  in  1  downstream accepts
- issue_op, issue_src1_idx, issue_src2_idx, issue_dst_idx, issue_imm  out  matching widths  selected entry fields
- occupancy  out  $clog2(RS_ENTRIES)+1  valid entry count

## Operation
- Per entry: valid, op, src1/src2 tag + ready bit, dst, imm. Age matrix older[i][j] (i older than j).
- Dispatch fires when disp_valid & disp_ready & !flush; writes the lowest-index free entry k; sets older[j][k]=1 for every valid j, older[k][*]=0.
- Source ready bit at dispatch = disp_srcN_rdy | (tag==0) | (any wb_valid[c] & wb_tag[c]==tag in the same cycle).
- Tag 0 is hardwired-ready (x0); wakeups with tag 0 are legal and harmless.
- Wakeup: each cycle, every valid entry sets srcN ready when any channel matches its tag; multiple channels matching the same tag are OR'd; ready bits never clear while valid.
- Select: candidate i = valid & src1 ready & src2 ready. Chosen entry is the candidate with no other candidate older than it. Exactly one or none.
- Issue fires when issue_valid & issue_ready; chosen entry's valid clears at that edge. If issue_ready is low, the same or an older newly-ready entry is shown next cycle (no hold requirement on fields).
- flush: all valid bits clear at the edge; dispatch and issue in that cycle do not take effect; issue_valid forced 0 while flush is high.
- occupancy = popcount(valid), registered.

## Timing
- Reset (async, rst_n low): all valid=0, age matrix 0, issue_valid=0, disp_ready=1, occupancy=0; output data fields 0.
- disp_ready = (occupancy != RS_ENTRIES), registered state only; a slot freed by an issue in cycle N is dispatchable in N+1, not N.
- Dispatch-to-issue latency: entry dispatched fully ready at edge N is visible on issue_valid in cycle N+1 (minimum 1 cycle).
- Wakeup-to-issue: wb in cycle N sets ready at edge N; entry eligible in cycle N+1.
- Issue outputs are combinational from registered entry state; no combinational path from disp_* or wb_* to issue_*.
- Simultaneous dispatch + issue: both occur; occupancy unchanged.
- Full (occupancy==RS_ENTRIES) with disp_valid: request ignored, no state change.
- Empty: issue_valid=0.
- rst_n asserted mid-operation clears everything immediately, regardless of clk.

## Test plan
- Reset, dispatch 3 ops all ready (dst 5,6,7), issue_ready=1 -> issue order dst 5,6,7 in cycles 1,2,3 after first dispatch; occupancy 1,1,1,0 pattern consistent.
- Dispatch A(src1=20 not ready), then B(ready) -> B issues first; wb_tag=20 on channel 3 -> A issues next cycle after wakeup.
- Dispatch op with src2=33 not ready while wb channel 0 carries tag 33 same cycle -> entry ready, issues one cycle later.
- Fill 8 entries with not-ready src=40, disp_valid held -> disp_ready=0, 9th not accepted, occupancy=8; wake 40 -> oldest issues first, disp_ready returns next cycle.
- 5 valid entries, issue_ready=1, flush pulsed -> issue_valid=0 that cycle, occupancy=0 next cycle, no issue fire.
- rst_n dropped asynchronously mid-stream with 4 entries -> issue_valid=0, occupancy=0, disp_ready=1 before next clk edge.
